// File: rtl/design_selector.sv
// Wishbone-controlled selector that owns each hosted design's reset and muxes the selected design onto the shared IO pads.
// Optional build macro DESIGN_SELECTOR_AUTOBOOT_EN: start design 0 automatically after reset release.
module design_selector #(
  parameter int          NUM_DESIGNS = 8,
  parameter int          IO_WIDTH    = 33,
  parameter int          SETTINGS_W  = 32,
  parameter int          HOLD_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic                            wb_clk_i,
  input  logic                            rst_n,
  input  logic                            wbs_cyc_i,
  input  logic                            wbs_stb_i,
  input  logic                            wbs_we_i,
  input  logic [3:0]                      wbs_sel_i,
  input  logic [31:0]                     wbs_adr_i,
  input  logic [31:0]                     wbs_dat_i,
  output logic                            wbs_ack_o,
  output logic [31:0]                     wbs_dat_o,
  input  logic [NUM_DESIGNS*IO_WIDTH-1:0] design_do,
  input  logic [NUM_DESIGNS*IO_WIDTH-1:0] design_oeb,
  output logic [NUM_DESIGNS-1:0]          design_rst_n,
  output logic [IO_WIDTH-1:0]             io_out,
  output logic [IO_WIDTH-1:0]             io_oeb,
  output logic [SETTINGS_W-1:0]           custom_settings,
  output logic                            irq
);

  localparam int                CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  HOLD_END = CNT_W'(HOLD_CYCLES);
  localparam logic [4:0]        NUM_D    = 5'(NUM_DESIGNS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                  state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [3:0]              cur_r;
  logic [3:0]              sel_idx_r;
  logic                    sel_en_r;
  logic                    err_r;
  logic                    done_r;
  logic                    irq_en_r;
  logic [SETTINGS_W-1:0]   settings_r;
  logic [NUM_DESIGNS-1:0]  rst_n_r;
  logic                    ack_r;
  logic [31:0]             dat_o_r;
`ifdef DESIGN_SELECTOR_AUTOBOOT_EN
  logic                    boot_r;
`endif

  logic        accept_s;
  logic        in_win_s;
  logic        wr_s;
  logic        sel_wr_s;
  logic        idx_ok_s;
  logic        sel_ok_s;
  logic        sel_bad_s;
  logic        set_wr_s;
  logic        irq_wr_s;
  logic        enter_run_s;
  logic [3:0]  new_idx_s;
  logic        new_en_s;
  logic [31:0] rd_data_s;

  // Wishbone decode and read-data selection
  always_comb begin
    accept_s    = wbs_cyc_i & wbs_stb_i & ~ack_r;
    in_win_s    = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    wr_s        = accept_s & wbs_we_i & in_win_s;
    new_idx_s   = wbs_dat_i[3:0];
    new_en_s    = wbs_dat_i[8];
    sel_wr_s    = wr_s & (wbs_adr_i[3:0] == 4'h0);
    idx_ok_s    = ({1'b0, new_idx_s} < NUM_D);
    sel_ok_s    = sel_wr_s & idx_ok_s;
    sel_bad_s   = sel_wr_s & ~idx_ok_s;
    set_wr_s    = wr_s & (wbs_adr_i[3:0] == 4'h4);
    irq_wr_s    = wr_s & (wbs_adr_i[3:0] == 4'hC);
    enter_run_s = (state_r == S_HOLD) & ~sel_ok_s & (cnt_r == HOLD_END);
    rd_data_s   = 32'd0;
    if (in_win_s) begin
      case (wbs_adr_i[3:0])
        4'h0:    rd_data_s = {23'd0, sel_en_r, 4'd0, sel_idx_r};
        4'h4:    rd_data_s = 32'(settings_r);
        4'h8:    rd_data_s = {22'd0, err_r, done_r, cur_r, 2'b00, state_r};
        4'hC:    rd_data_s = {31'd0, irq_en_r};
        default: rd_data_s = 32'd0;
      endcase
    end else begin
      rd_data_s = 32'd0;
    end
  end

  // Single-cycle ack with registered read data; ack blocks re-acceptance for one cycle
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_r   <= 1'b0;
      dat_o_r <= 32'd0;
    end else begin
      ack_r   <= accept_s;
      dat_o_r <= accept_s ? rd_data_s : 32'd0;
    end
  end

  // Settings word, byte-masked, plus interrupt enable and the done flag (set beats clear)
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      settings_r <= {SETTINGS_W{1'b0}};
      irq_en_r   <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      for (int i = 0; i < SETTINGS_W; i++) begin
        if (set_wr_s && wbs_sel_i[i/8]) begin
          settings_r[i] <= wbs_dat_i[i];
        end
      end
      if (irq_wr_s) begin
        irq_en_r <= wbs_dat_i[0];
      end
      if (enter_run_s) begin
        done_r <= 1'b1;
      end else if (irq_wr_s && wbs_dat_i[16]) begin
        done_r <= 1'b0;
      end
    end
  end

  // Switch sequencer: hold every design in reset, then release only the selected one
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      cur_r     <= 4'd0;
      sel_idx_r <= 4'd0;
      sel_en_r  <= 1'b0;
      err_r     <= 1'b0;
      rst_n_r   <= {NUM_DESIGNS{1'b0}};
`ifdef DESIGN_SELECTOR_AUTOBOOT_EN
      boot_r    <= 1'b1;
`endif
    end else begin
`ifdef DESIGN_SELECTOR_AUTOBOOT_EN
      boot_r <= 1'b0;
`endif
      if (sel_bad_s) begin
        err_r <= 1'b1;
      end else if (sel_ok_s) begin
        err_r <= 1'b0;
      end
      if (sel_ok_s) begin
        sel_idx_r <= new_idx_s;
        sel_en_r  <= new_en_s;
      end
      case (state_r)
        S_IDLE: begin
          if (sel_ok_s && new_en_s) begin
            state_r <= S_HOLD;
            cnt_r   <= {CNT_W{1'b0}};
            cur_r   <= new_idx_s;
`ifdef DESIGN_SELECTOR_AUTOBOOT_EN
          end else if (boot_r && !sel_ok_s) begin
            state_r   <= S_HOLD;
            cnt_r     <= {CNT_W{1'b0}};
            cur_r     <= 4'd0;
            sel_idx_r <= 4'd0;
            sel_en_r  <= 1'b1;
`endif
          end
        end
        S_HOLD: begin
          if (sel_ok_s) begin
            if (new_en_s) begin
              cur_r <= new_idx_s;
              cnt_r <= {CNT_W{1'b0}};
            end else begin
              state_r <= S_IDLE;
            end
          end else if (cnt_r == HOLD_END) begin
            state_r <= S_RUN;
            rst_n_r <= {{(NUM_DESIGNS-1){1'b0}}, 1'b1} << cur_r;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (sel_ok_s) begin
            if (!new_en_s) begin
              state_r <= S_IDLE;
              rst_n_r <= {NUM_DESIGNS{1'b0}};
            end else if (new_idx_s != cur_r) begin
              state_r <= S_HOLD;
              cnt_r   <= {CNT_W{1'b0}};
              cur_r   <= new_idx_s;
              rst_n_r <= {NUM_DESIGNS{1'b0}};
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          rst_n_r <= {NUM_DESIGNS{1'b0}};
        end
      endcase
    end
  end

  // Pad routing follows the registered state, so pads stay tri-stated until the design is released
  always_comb begin
    if (state_r == S_RUN) begin
      io_out = design_do[int'(cur_r)*IO_WIDTH +: IO_WIDTH];
      io_oeb = design_oeb[int'(cur_r)*IO_WIDTH +: IO_WIDTH];
    end else begin
      io_out = {IO_WIDTH{1'b0}};
      io_oeb = {IO_WIDTH{1'b1}};
    end
  end

  assign wbs_ack_o       = ack_r;
  assign wbs_dat_o       = dat_o_r;
  assign design_rst_n    = rst_n_r;
  assign custom_settings = settings_r;
  assign irq             = done_r & irq_en_r;

endmodule
